recompositor_7bit: RTL and testbench

- Sequential shift-and-add block that rebuilds a dividend from quotient, divisor and remainder: P = Q*B + R.
- It is the inverse path of the team's 7-bit restoring divider. It serves as an on-chip checker: the divider's A is fed as A_ref, and the block flags whether the recomposition matches.
- One multiplier bit is processed per clock, under a start/done handshake matching the divider's.

---
 rtl/recompositor_7bit.sv | 117 +++++++++++
 tb/tb_recompositor_7bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/recompositor_7bit.sv
// Shift-and-add recomposer: rebuilds P = Q*B + R one multiplier bit per clock
// and flags whether the result equals the expected dividend A_ref.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; done/P/match hold the last result
// RUN   | one shift-and-add iteration per edge, WIDTH iterations total
module recompositor_7bit #(
   parameter int WIDTH = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     Q,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-1:0]     R,
   input  logic [WIDTH-1:0]     A_ref,
   output logic [2*WIDTH-1:0]   P,
   output logic                 match,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mult_q, mult_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     aref_q, aref_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic                 match_q, match_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   acc_sum;

   // Next-state and datapath: load operands in IDLE, shift-and-add in RUN.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mult_d  = mult_q;
      cnt_d   = cnt_q;
      aref_d  = aref_q;
      p_d     = p_q;
      match_d = match_q;
      busy_d  = busy_q;
      done_d  = done_q;
      acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = {{WIDTH{1'b0}}, R};
               mcand_d = {{WIDTH{1'b0}}, B};
               mult_d  = Q;
               cnt_d   = CW'(WIDTH);
               aref_d  = A_ref;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               match_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mult_d  = mult_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               p_d     = acc_sum;
               match_d = (acc_sum == {{WIDTH{1'b0}}, aref_q});
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mult_q  <= '0;
         cnt_q   <= '0;
         aref_q  <= '0;
         p_q     <= '0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         cnt_q   <= cnt_d;
         aref_q  <= aref_d;
         p_q     <= p_d;
         match_q <= match_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign P     = p_q;
   assign match = match_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_recompositor_7bit.sv
// Bench for recompositor_7bit: directed vector table, handshake/reset
// sequences, and random operations against an arithmetic reference model.
module tb_recompositor_7bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [6:0]  Q, B, R, A_ref;
   logic [13:0] P;
   logic        match, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [6:0]  q;
      logic [6:0]  b;
      logic [6:0]  r;
      logic [6:0]  aref;
      logic [13:0] p;
      logic        m;
   } vec_t;

   vec_t vecs[5];

   recompositor_7bit #(.WIDTH(7)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Q     (Q),
      .B     (B),
      .R     (R),
      .A_ref (A_ref),
      .P     (P),
      .match (match),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: unsigned recomposition with plain arithmetic.
   function automatic logic [13:0] ref_p(input logic [6:0] q, b, r);
      int v;
      v = int'(q) * int'(b) + int'(r);
      return v[13:0];
   endfunction

   // Waits (bounded) for done; returns edges elapsed from the current point.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   // Called #1 after a rising edge. Start is accepted on the next edge.
   task automatic run_op(input logic [6:0] q, b, r, aref,
                         input logic [13:0] exp_p, input logic exp_m,
                         input string tag);
      int cyc;
      Q = q; B = b; R = r; A_ref = aref; start = 1'b1;
      @(posedge clk); #1;
      check({tag, "_busy_at_accept"}, busy, 1);
      check({tag, "_done_clr_at_accept"}, done, 0);
      start = 1'b0;
      Q = 7'($urandom); B = 7'($urandom); R = 7'($urandom); A_ref = 7'($urandom);
      wait_done(cyc);
      check({tag, "_latency"}, cyc, 7);
      check({tag, "_P"}, P, exp_p);
      check({tag, "_match"}, match, exp_m);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      int cyc;
      logic [13:0] p_hold;
      logic [6:0]  rq, rb, rr, ra;
      logic [13:0] rp;

      vecs[0] = '{q: 7'd14,  b: 7'd7,   r: 7'd2,   aref: 7'd100, p: 14'd100,   m: 1'b1};
      vecs[1] = '{q: 7'd127, b: 7'd127, r: 7'd127, aref: 7'd0,   p: 14'd16256, m: 1'b0};
      vecs[2] = '{q: 7'd127, b: 7'd1,   r: 7'd0,   aref: 7'd127, p: 14'd127,   m: 1'b1};
      vecs[3] = '{q: 7'd5,   b: 7'd0,   r: 7'd3,   aref: 7'd3,   p: 14'd3,     m: 1'b1};
      vecs[4] = '{q: 7'd0,   b: 7'd0,   r: 7'd0,   aref: 7'd0,   p: 14'd0,     m: 1'b1};

      rst = 1'b0; start = 1'b0; Q = '0; B = '0; R = '0; A_ref = '0;

      // Asynchronous reset asserted between edges.
      #2 rst = 1'b1;
      #1;
      check("reset_P", P, 0);
      check("reset_match", match, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("idle_no_start_done", done, 0);

      // Directed table.
      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].q, vecs[i].b, vecs[i].r, vecs[i].aref, vecs[i].p, vecs[i].m,
                $sformatf("vec%0d", i));
         if (i == 0) begin
            p_hold = P;
            repeat (3) @(posedge clk);
            #1;
            check("vec0_done_held", done, 1);
            check("vec0_P_held", P, p_hold);
            check("vec0_match_held", match, 1);
         end
      end

      // Start re-pulsed while busy must be ignored.
      Q = 7'd3; B = 7'd3; R = 7'd0; A_ref = 7'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      Q = 7'd9; B = 7'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(cyc);
      check("busy_restart_latency", cyc + 2, 7);
      check("busy_restart_P", P, 9);
      check("busy_restart_match", match, 1);

      // Back-to-back: start on the cycle right after done rose.
      run_op(7'd2, 7'd5, 7'd1, 7'd11, 14'd11, 1'b1, "b2b");

      // Start held high: restarts on the first IDLE cycle after done.
      Q = 7'd6; B = 7'd9; R = 7'd4; A_ref = 7'd58; start = 1'b1;
      @(posedge clk); #1;
      wait_done(cyc);
      check("held_first_P", P, 58);
      @(posedge clk); #1;
      check("held_restart_done", done, 0);
      check("held_restart_busy", busy, 1);
      start = 1'b0;
      wait_done(cyc);
      check("held_second_P", P, 58);

      // Reset in the middle of an operation.
      Q = 7'd10; B = 7'd10; R = 7'd0; A_ref = 7'd100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_P", P, 0);
      check("midrst_match", match, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      #1 rst = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("midrst_idle_done", done, 0);
      check("midrst_idle_busy", busy, 0);
      run_op(7'd6, 7'd4, 7'd3, 7'd27, 14'd27, 1'b1, "after_rst");

      // Random operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         rq = 7'($urandom); rb = 7'($urandom); rr = 7'($urandom);
         if (i % 4 == 0) rb = 7'($urandom_range(0, 3));
         if (i % 5 == 0) rq = 7'($urandom_range(0, 2));
         rp = ref_p(rq, rb, rr);
         ra = ($urandom_range(0, 1) == 1) ? rp[6:0] : 7'($urandom);
         run_op(rq, rb, rr, ra, rp, (rp == {7'd0, ra}), $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
